// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
// State encoding, default sizes and one-hot decode.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 4;

  // Sized for the largest supported requester count (8).
  function automatic logic [2:0] oh2idx(
    input logic [7:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/arbiter bundle for the shared holding register.
// master = requester side, slave = arbiter side.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic                reg_en;
  logic [DW-1:0]       reg_din;
  logic                busy;

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  ack,
    input  reg_en,
    input  reg_din,
    input  busy
  );

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output ack,
    output reg_en,
    output reg_din,
    output busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest
// index when REG_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx
);

`ifdef REG_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  always_comb begin
    logic found;
    win_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        win_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    int   k;
    win_oh = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k[IDX_W-1:0]]) begin
        win_oh[k[IDX_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end
`endif

  assign win_idx = IDX_W'(oh2idx(8'(win_oh)));

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates writes into one shared enable-loaded register.
// Build option: REG_ARB_FIXED_PRIO_EN selects fixed priority.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_write_arbiter_if.slave bus
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic [DW-1:0]    pick;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_comb begin
    pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) pick = pick | bus.wdata[i*DW +: DW];
    end
  end

`ifdef REG_ARB_FIXED_PRIO_EN
  logic win_idx_unused;
  assign win_idx_unused = ^win_idx;
`else
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_ptr;
  logic             win_idx_unused;

  assign win_idx_unused = ^win_idx;
  assign cur_idx = IDX_W'(oh2idx(8'(bus.gnt)));
  assign nxt_ptr = (cur_idx == IDX_W'(N_REQ - 1))
                 ? '0 : cur_idx + 1'b1;
`endif

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      bus.gnt     <= '0;
      bus.ack     <= '0;
      bus.reg_en  <= 1'b0;
      bus.reg_din <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.gnt     <= win_oh;
            bus.reg_din <= pick;
            bus.reg_en  <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          bus.reg_en <= 1'b0;
          bus.ack    <= bus.gnt;
          state      <= DONE;
        end
        DONE: begin
          bus.ack <= '0;
          bus.gnt <= '0;
`ifdef REG_ARB_FIXED_PRIO_EN
`else
          ptr     <= nxt_ptr;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with hand-computed results.
// Expectations follow REG_ARB_FIXED_PRIO_EN when it is defined.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_write_arbiter_if #(.N_REQ(4), .DW(4)) bus ();

  reg_write_arbiter #(.N_REQ(4), .DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_en"}, 32'(bus.reg_en), 32'd0);
  endtask

  logic [3:0] rot_din [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
  logic [3:0] rot_gnt [5] = '{4'b0001, 4'b0010, 4'b0100,
                              4'b1000, 4'b0001};
`ifdef REG_ARB_FIXED_PRIO_EN
  localparam logic [3:0] PRIO_GNT = 4'b0001;
  localparam logic [3:0] PRIO_DIN = 4'hC;
`else
  localparam logic [3:0] PRIO_GNT = 4'b1000;
  localparam logic [3:0] PRIO_DIN = 4'hB;
`endif

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    #12;
    chk_idle("rst");
    chk("rst_din", 32'(bus.reg_din), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("noreq");
    end
    chk("noreq_din", 32'(bus.reg_din), 32'd0);

    // Single request from requester 2
    bus.req   = 4'b0100;
    bus.wdata = 16'h0A00;
    tick();
    chk("one_en", 32'(bus.reg_en), 32'd1);
    chk("one_din", 32'(bus.reg_din), 32'hA);
    chk("one_gnt", 32'(bus.gnt), 32'b0100);
    chk("one_busy", 32'(bus.busy), 32'd1);
    chk("one_ack0", 32'(bus.ack), 32'd0);
    tick();
    chk("one_ack", 32'(bus.ack), 32'b0100);
    chk("one_en0", 32'(bus.reg_en), 32'd0);
    bus.req = '0;
    tick();
    chk_idle("one_end");

    // Restart from ptr=0 for the rotation sequence
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = 16'h4321;
`ifdef REG_ARB_FIXED_PRIO_EN
    rot_din = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    rot_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rot_en", 32'(bus.reg_en), 32'd1);
      chk("rot_din", 32'(bus.reg_din), 32'(rot_din[k]));
      chk("rot_gnt", 32'(bus.gnt), 32'(rot_gnt[k]));
      tick();
      chk("rot_ack", 32'(bus.ack), 32'(rot_gnt[k]));
      chk("rot_en0", 32'(bus.reg_en), 32'd0);
      if (k == 4) bus.req = '0;
      tick();
      chk("rot_busy", 32'(bus.busy), 32'd0);
    end

    // ptr now 1: requester 3 beats requester 0
    bus.req   = 4'b1001;
    bus.wdata = 16'hB00C;
    tick();
    chk("prio_gnt", 32'(bus.gnt), 32'(PRIO_GNT));
    chk("prio_din", 32'(bus.reg_din), 32'(PRIO_DIN));
    tick();
    chk("prio_ack", 32'(bus.ack), 32'(PRIO_GNT));
    bus.req = '0;
    tick();
    chk_idle("prio_end");

    // Drop req and change data mid-write
    bus.req   = 4'b0010;
    bus.wdata = 16'h0050;
    tick();
    chk("drop_din", 32'(bus.reg_din), 32'h5);
    chk("drop_gnt", 32'(bus.gnt), 32'b0010);
    bus.req   = '0;
    bus.wdata = 16'h00F0;
    tick();
    chk("drop_ack", 32'(bus.ack), 32'b0010);
    chk("drop_hold", 32'(bus.reg_din), 32'h5);
    tick();
    chk_idle("drop_end");
    tick();
    chk_idle("drop_idle");

    // Reset while in WRITE
    bus.req   = 4'b0100;
    bus.wdata = 16'h0300;
    tick();
    chk("rw_gnt", 32'(bus.gnt), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rw_async");
    chk("rw_din", 32'(bus.reg_din), 32'd0);
    tick();
    chk_idle("rw_held");
    rst_n = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = 16'h4321;
    tick();
    chk("rw_first", 32'(bus.gnt), 32'b0001);
    chk("rw_fdin", 32'(bus.reg_din), 32'h1);
    bus.req = '0;
    tick();
    chk("rw_ack", 32'(bus.ack), 32'b0001);
    tick();
    chk_idle("rw_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares one enable-loaded 4-bit register between several requesters.
- Each requester raises req with its data; the block grants one requester at a time.
- Grant drives the shared register's enable and data inputs for exactly one clock, then returns a one-cycle ack to the winner.
- Sits between the lab datapath sources (switch/keypad/counter logic) and the shared holding register.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 4, data width of each requester and of the shared register
IDX_W, $clog2(N_REQ), width of the winner index (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester write request, level, held until ack
wdata  input  N_REQ*DW  packed write data; requester i uses bits [i*DW +: DW]
gnt  output  N_REQ  one-hot grant, registered
ack  output  N_REQ  one-hot, one-cycle completion pulse, registered
reg_en  output  1  enable to the shared register, registered
reg_din  output  DW  data to the shared register, registered
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset state (rst_n low, asynchronous):
  - state=IDLE; gnt=0, ack=0, reg_en=0, reg_din=0, busy=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority first.
- FSM states: IDLE, WRITE, DONE. The path is always IDLE->WRITE->DONE->IDLE, with no stalls.
- IDLE, req==0: stay in IDLE, all outputs 0.
- IDLE, req!=0:
  - Winner w = first set bit searching upward from ptr, wrapping modulo N_REQ.
  - At the edge: gnt<=onehot(w), reg_din<=wdata slice w, reg_en<=1, go to WRITE.
- WRITE (1 cycle):
  - reg_en=1, so the shared register loads reg_din at the closing edge.
  - At that edge: reg_en<=0, ack<=gnt, go to DONE.
- DONE (1 cycle):
  - ack pulse visible.
  - At the edge: ack<=0, gnt<=0, reg_din holds its value, ptr<=(w+1) mod N_REQ, go to IDLE.
- Latency: req sampled at edge E0; register loads at E1; ack high between E1 and E2. Throughput is one write per 3 cycles.
- Data capture:
  - wdata is sampled only at the IDLE->WRITE edge.
  - Later changes to wdata, or dropping req during WRITE/DONE, do not abort or alter the write; ack is still issued.
- Re-request: a req still high in IDLE after its ack is a new request. The updated ptr guarantees other pending requesters win first.
- Fairness: with all N_REQ requests held high, grants rotate 0,1,2,...,N_REQ-1,0,...
- Simultaneous requests are resolved only by ptr; no requester waits more than N_REQ-1 other writes.
- Reset mid-operation:
  - Any state returns to IDLE immediately and all outputs clear.
  - A write whose reg_en edge has not occurred is lost, and no ack is issued.
- gnt, ack and reg_en are never high while busy=0. ack is never high in the same cycle as reg_en.

Optional Feature:
Macro: REG_ARB_FIXED_PRIO_EN
- Defined: fixed priority. The winner is the lowest-index set req, ptr is not used or updated, and requester 0 can starve others.
- Undefined (default): round-robin as specified above.
- Timing, ports and FSM are identical in both builds.

Decomposition:
- Shared package reg_arb_pkg:
  - FSM state enum (IDLE=2'd0, WRITE=2'd1, DONE=2'd2).
  - Default N_REQ/DW constants.
  - onehot-to-index function.
- Sub-module rr_pick: combinational; inputs req and ptr, outputs onehot winner and index.
  - Also compiled with REG_ARB_FIXED_PRIO_EN to yield lowest-index selection.
- FSM, ptr and output registers stay in reg_write_arbiter.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> busy, gnt, ack and reg_en all stay 0; reg_din=0.
- Single request, req=4'b0100 with wdata slice 2=4'hA:
  - reg_en=1 and reg_din=4'hA in the cycle after sampling.
  - ack=4'b0100 in the next cycle; busy low 3 cycles after the request.
- All four held high, slices 4'h1,4'h2,4'h3,4'h4 -> reg_din sequence 1,2,3,4,1 on successive reg_en pulses, one every 3 cycles.
- req=4'b1001 after a write by requester 0 (ptr=1) -> requester 3 is granted before requester 0.
  - With REG_ARB_FIXED_PRIO_EN defined, requester 0 is granted instead.
- Requester 1 drops req and changes wdata to 4'hF during WRITE -> the originally sampled value is written and ack=4'b0010 still pulses.
- Assert rst_n low during WRITE -> outputs clear asynchronously, no ack is issued, and after release ptr=0 with requester 0 first.
